// File: rtl/key_pkg.sv
// Shared key codes and controller state type for the front-panel key path.
package key_pkg;

    localparam int unsigned KEY_W = 8;

    localparam logic [KEY_W-1:0] KEY_MENU   = 8'b1000_0000;
    localparam logic [KEY_W-1:0] KEY_SET    = 8'b0100_0000;
    localparam logic [KEY_W-1:0] KEY_CANCEL = 8'b0010_0000;
    localparam logic [KEY_W-1:0] KEY_UP     = 8'b0001_0000;
    localparam logic [KEY_W-1:0] KEY_DOWN   = 8'b0000_1000;

    typedef enum logic [1:0] {
        IDLE,
        HELD_WAIT,
        REPEAT
    } key_state_e;

    function automatic logic [KEY_W-1:0] idx_to_key(input logic [2:0] idx);
        return KEY_W'(1) << idx;
    endfunction

    // Only navigation keys may auto-repeat
    function automatic logic is_repeatable(input logic [2:0] idx);
        logic [KEY_W-1:0] code;
        code = idx_to_key(idx);
        return (code == KEY_UP) || (code == KEY_DOWN);
    endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// One button: 2-flop synchronizer plus consecutive-stable-cycle filter.
module key_debounce_bit #(
    parameter int DEB_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            rise <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt >= CNT_LAST) begin
                level <= sync[1];
                rise  <= sync[1];
                cnt   <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Eight-button debouncer with single-owner key event FSM.
// Define KEY_REPEAT_EN to enable UP/DOWN auto-repeat.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEB_CYCLES   = 20000,
    parameter int REPEAT_DELAY = 500000,
    parameter int REPEAT_RATE  = 100000
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [KEY_W-1:0] BTN_RAW,
    output logic [KEY_W-1:0] KEY,
    output logic             HELD
);

    localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] DLY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LAST = TW'(REPEAT_RATE - 1);

    logic [KEY_W-1:0] level;
    logic [KEY_W-1:0] rise;
    logic [2:0]       pick_idx;
    logic             pick_vld;

    key_state_e  state;
    logic [2:0]  owner;
    logic [TW-1:0] timer;

    for (genvar i = 0; i < KEY_W; i++) begin : g_bit
        key_debounce_bit #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_bit (
            .clk  (CLK),
            .rst_n(RESETN),
            .btn  (BTN_RAW[i]),
            .level(level[i]),
            .rise (rise[i])
        );
    end

    // Highest index wins when several keys settle together
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int i = 0; i < KEY_W; i++) begin
            if (rise[i]) begin
                pick_idx = 3'(i);
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state <= IDLE;
            owner <= '0;
            timer <= '0;
            KEY   <= '0;
            HELD  <= 1'b0;
        end else begin
            KEY <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        KEY   <= idx_to_key(pick_idx);
                        owner <= pick_idx;
                        timer <= '0;
                        HELD  <= 1'b1;
                        state <= HELD_WAIT;
                    end
                end
                HELD_WAIT: begin
                    if (!level[owner]) begin
                        HELD  <= 1'b0;
                        state <= IDLE;
`ifdef KEY_REPEAT_EN
                    end else if (is_repeatable(owner) && timer >= DLY_LAST) begin
                        KEY   <= idx_to_key(owner);
                        timer <= '0;
                        state <= REPEAT;
`endif
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!level[owner]) begin
                        HELD  <= 1'b0;
                        state <= IDLE;
                    end else if (timer >= RATE_LAST) begin
                        KEY   <= idx_to_key(owner);
                        timer <= '0;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    HELD  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Randomized and directed bench for key_debounce against a cycle-level model.
module tb_key_debounce;

    localparam int DEB   = 4;
    localparam int DELAY = 10;
    localparam int RATE  = 3;

`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic [7:0] BTN_RAW = '0;
    logic [7:0] KEY;
    logic       HELD;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic [7:0] m_s1, m_s2, m_deb, m_deb_prev, m_last_sv;
    int         m_run [8];
    bit         m_owned;
    int         m_owner;
    int         m_t;
    logic [7:0] exp_key;
    bit         exp_held;

    // scenario bookkeeping
    int         pulses;
    int         first_edge;
    int         edge_n;
    logic [7:0] pulse_or;

    logic [7:0] pat, v;
    int         len, sel;

    always #5 CLK = ~CLK;

    key_debounce #(
        .DEB_CYCLES  (DEB),
        .REPEAT_DELAY(DELAY),
        .REPEAT_RATE (RATE)
    ) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .BTN_RAW(BTN_RAW),
        .KEY    (KEY),
        .HELD   (HELD)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_deb_prev = '0; m_last_sv = '0;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
        m_owned = 0; m_owner = 0; m_t = 0;
        exp_key = '0; exp_held = 0;
    endtask

    // One rising edge, with raw the level present before that edge.
    task automatic model_edge(input logic [7:0] raw);
        logic [7:0] rise_m;
        logic       sv;
        int         hi;
        rise_m  = m_deb & ~m_deb_prev;
        exp_key = '0;
        if (!m_owned) begin
            if (rise_m != 0) begin
                hi = 0;
                for (int i = 0; i < 8; i++) if (rise_m[i]) hi = i;
                exp_key = 8'h1 << hi;
                m_owned = 1; m_owner = hi; m_t = 0;
            end
        end else if (!m_deb[m_owner]) begin
            m_owned = 0;
        end else begin
            m_t++;
            if (REP_EN && (m_owner == 4 || m_owner == 3) && m_t >= DELAY
                && ((m_t - DELAY) % RATE) == 0)
                exp_key = 8'h1 << m_owner;
        end
        exp_held = m_owned;
        // a level is accepted once the synced value has sat at it for DEB edges
        m_deb_prev = m_deb;
        for (int i = 0; i < 8; i++) begin
            sv = m_s2[i];
            m_run[i] = (sv == m_last_sv[i]) ? m_run[i] + 1 : 1;
            m_last_sv[i] = sv;
            if (sv != m_deb[i] && m_run[i] >= DEB) m_deb[i] = sv;
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic mark();
        pulses = 0; first_edge = -1; edge_n = 0; pulse_or = '0;
    endtask

    task automatic cycle(input logic [7:0] raw);
        BTN_RAW = raw;
        @(posedge CLK);
        model_edge(raw);
        #1;
        edge_n++;
        if (KEY != 0) begin
            pulses++;
            pulse_or |= KEY;
            if (first_edge < 0) first_edge = edge_n;
        end
        check("key", 32'(KEY), 32'(exp_key));
        check("held", 32'(HELD), 32'(exp_held));
        check("onehot", 32'($countones(KEY) <= 1), 32'd1);
    endtask

    task automatic do_reset(input int n);
        RESETN = 1'b0;
        #1;
        model_reset();
        check("rst_key", 32'(KEY), 32'h0);
        check("rst_held", 32'(HELD), 32'h0);
        repeat (n) @(posedge CLK);
        @(negedge CLK);
        RESETN = 1'b1;
    endtask

    initial begin
        model_reset();
        mark();
        RESETN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_key", 32'(KEY), 32'h0);
        check("reset_held", 32'(HELD), 32'h0);
        @(negedge CLK);
        RESETN = 1'b1;

        // MENU held steady, then released
        mark();
        repeat (20) cycle(8'h80);
        repeat (15) cycle(8'h00);
        check("menu_latency", 32'(first_edge), 32'd7);
        check("menu_pulses", 32'(pulses), 32'd1);
        check("menu_code", 32'(pulse_or), 32'h80);

        // CANCEL bouncing never settles
        mark();
        for (int c = 0; c < 20; c++) cycle(((c / 2) % 2) ? 8'h00 : 8'h20);
        repeat (15) cycle(8'h00);
        check("bounce_pulses", 32'(pulses), 32'd0);

        // MENU and UP together, then UP alone
        mark();
        repeat (15) cycle(8'h90);
        repeat (15) cycle(8'h10);
        repeat (15) cycle(8'h00);
        check("dual_pulses", 32'(pulses), 32'd1);
        check("dual_code", 32'(pulse_or), 32'h80);

        // UP held 30 cycles
        mark();
        repeat (30) cycle(8'h10);
        repeat (15) cycle(8'h00);
        check("up_first", 32'(first_edge), 32'd7);
        check("up_pulses", 32'(pulses), REP_EN ? 32'd8 : 32'd1);

        // reset while SET is in HELD_WAIT, SET kept held
        mark();
        repeat (10) cycle(8'h40);
        check("pre_rst_held", 32'(HELD), 32'd1);
        do_reset(2);
        mark();
        repeat (12) cycle(8'h40);
        check("post_rst_latency", 32'(first_edge), 32'd7);
        repeat (15) cycle(8'h00);

        // randomized phases
        for (int p = 0; p < 250; p++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 5) pat = 8'h1 << $urandom_range(3, 7);
            else if (sel < 8) pat = 8'($urandom);
            else pat = 8'h00;
            len = int'($urandom_range(1, 35));
            for (int c = 0; c < len; c++) begin
                v = pat;
                if (c < 4 && $urandom_range(0, 2) == 0) v = pat ^ 8'($urandom);
                cycle(v);
            end
            if ($urandom_range(0, 24) == 0) do_reset(int'($urandom_range(1, 3)));
        end
        repeat (15) cycle(8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
